accu_alu_cpu: RTL and testbench

- Small accumulator-based 8-bit datapath: one accumulator (ACCU) plus seven general registers REG0..REG6, and an ALU.
- `opcode` selects a register and an ALU operation.
- In load mode, `data_in` is written into the selected register.
- In execute mode, ACCU is replaced by `ACCU op selected_register`, with a carry/borrow flag.
- Used as the leaf CPU core of the ALU homework design; `data_out` always shows ACCU.

---
 rtl/accu_alu_cpu.sv | 113 +++++++++++
 tb/tb_accu_alu_cpu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/accu_alu_cpu.sv
// Accumulator-based datapath: ACCU plus seven general registers feeding an ALU.
// Optional macro ZERO_FLAG_EN adds a registered `zero` result flag.
module accu_alu_cpu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [6:0]       opcode,
    input  logic             cin,
    output logic             cout,
    input  logic             load,
    input  logic             ce,
`ifdef ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_LSHIFT = 4'h2,
        OP_RSHIFT = 4'h3,
        OP_XOR    = 4'h4,
        OP_CMP    = 4'h5,
        OP_AND    = 4'h6,
        OP_NAND   = 4'h7,
        OP_OR     = 4'h8,
        OP_NOR    = 4'h9,
        OP_CPY    = 4'hA
    } alu_op_e;

    logic [WIDTH-1:0] accu;
    // Indexed directly by the 3-bit select; select 0 means ACCU itself.
    logic [WIDTH-1:0] reg_file [1:7];

    logic [2:0]       sel;
    alu_op_e          op;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             alu_en;
    logic [WIDTH-1:0] alu_accu;
    logic             alu_cout;
    logic             alu_zero;

    assign sel      = opcode[6:4];
    assign op       = alu_op_e'(opcode[3:0]);
    assign data_out = accu;

    assign operand_b = (sel == 3'd0) ? accu : reg_file[sel];
    assign sum  = {1'b0, accu} + {1'b0, operand_b} + {{WIDTH{1'b0}}, cin};
    // The extra MSB of a widened subtraction is the borrow out.
    assign diff = {1'b0, accu} - {1'b0, operand_b} - {{WIDTH{1'b0}}, cin};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        alu_en   = 1'b1;
        alu_accu = accu;
        alu_cout = 1'b0;
        case (op)
            OP_ADD:    {alu_cout, alu_accu} = sum;
            OP_SUB:    {alu_cout, alu_accu} = diff;
            OP_LSHIFT: begin
                alu_accu = {accu[WIDTH-2:0], cin};
                alu_cout = accu[WIDTH-1];
            end
            OP_RSHIFT: begin
                alu_accu = {cin, accu[WIDTH-1:1]};
                alu_cout = accu[0];
            end
            OP_XOR:    alu_accu = accu ^ operand_b;
            OP_CMP:    alu_cout = (accu < operand_b);
            OP_AND:    alu_accu = accu & operand_b;
            OP_NAND:   alu_accu = ~(accu & operand_b);
            OP_OR:     alu_accu = accu | operand_b;
            OP_NOR:    alu_accu = ~(accu | operand_b);
            OP_CPY:    alu_accu = operand_b;
            default:   alu_en   = 1'b0;
        endcase
        alu_zero = (op == OP_CMP) ? (accu == operand_b) : (alu_accu == '0);
    end

    // NOTE: the register file is small and architecturally visible, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accu <= '0;
            cout <= 1'b0;
            for (int i = 1; i <= 7; i++) reg_file[i] <= '0;
`ifdef ZERO_FLAG_EN
            zero <= 1'b0;
`endif
        end else if (ce) begin
            if (load) begin
                if (sel == 3'd0) accu <= data_in;
                else             reg_file[sel] <= data_in;
            end else if (alu_en) begin
                accu <= alu_accu;
                cout <= alu_cout;
`ifdef ZERO_FLAG_EN
                zero <= alu_zero;
`endif
            end
        end
    end

`ifndef ZERO_FLAG_EN
    logic unused_zero;
    assign unused_zero = alu_zero;
`endif

endmodule

// File: tb/tb_accu_alu_cpu.sv
// Directed self-checking bench for accu_alu_cpu with hand-computed expectations.
module tb_accu_alu_cpu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic [6:0] opcode;
    logic       cin;
    logic       cout;
    logic       load;
    logic       ce;
    logic [7:0] data_out;
`ifdef ZERO_FLAG_EN
    logic       zero;
`endif

    int checks = 0;
    int errors = 0;

    accu_alu_cpu #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .opcode   (opcode),
        .cin      (cin),
        .cout     (cout),
        .load     (load),
        .ce       (ce),
`ifdef ZERO_FLAG_EN
        .zero     (zero),
`endif
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Apply one set of inputs across one rising edge; outputs sampled 1 time unit later.
    task automatic step(input logic l, input logic c, input logic [6:0] op,
                        input logic [7:0] d, input logic ci);
        load = l; ce = c; opcode = op; data_in = d; cin = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [2:0] sel, input logic [7:0] d);
        step(1'b1, 1'b1, {sel, 4'h0}, d, 1'b0);
    endtask

    task automatic exec(input logic [2:0] sel, input logic [3:0] op, input logic ci);
        step(1'b0, 1'b1, {sel, op}, 8'h00, ci);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; ce = 1'b0; opcode = '0; data_in = '0; cin = 1'b0;
        #12;
        check("reset_data", data_out, 8'h00);
        check("reset_cout", {7'd0, cout}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        for (int s = 0; s < 8; s++) load_reg(3'(s), 8'(1 << s));
        check("load_accu", data_out, 8'h01);

        for (int s = 0; s < 8; s++) begin
            exec(3'(s), 4'hA, 1'b0);
            check($sformatf("cpy_sel%0d", s), data_out, (s == 0) ? 8'h01 : 8'(1 << s));
            check($sformatf("cpy_cout%0d", s), {7'd0, cout}, 8'h00);
        end

        load_reg(3'd0, 8'h01);
        exec(3'd1, 4'h0, 1'b0);
        check("add_reg0", data_out, 8'h03);
        check("add_reg0_cout", {7'd0, cout}, 8'h00);
        exec(3'd0, 4'h1, 1'b0);
        check("sub_self", data_out, 8'h00);
        check("sub_self_cout", {7'd0, cout}, 8'h00);
`ifdef ZERO_FLAG_EN
        check("zero_after_sub", {7'd0, zero}, 8'h01);
`endif

        exec(3'd1, 4'h0, 1'b1);
        check("add_cin", data_out, 8'h03);
`ifdef ZERO_FLAG_EN
        check("zero_cleared", {7'd0, zero}, 8'h00);
`endif
        exec(3'd0, 4'h2, 1'b0);
        check("lshift0", data_out, 8'h06);
        exec(3'd0, 4'h2, 1'b1);
        check("lshift1", data_out, 8'h0D);
        check("lshift1_cout", {7'd0, cout}, 8'h00);
        exec(3'd0, 4'h3, 1'b1);
        check("rshift1", data_out, 8'h86);
        check("rshift1_cout", {7'd0, cout}, 8'h01);
        exec(3'd0, 4'h2, 1'b0);
        check("lshift_msb", data_out, 8'h0C);
        check("lshift_msb_cout", {7'd0, cout}, 8'h01);

        load_reg(3'd0, 8'hFF);
        exec(3'd2, 4'h0, 1'b0);
        check("add_wrap", data_out, 8'h03);
        check("add_wrap_cout", {7'd0, cout}, 8'h01);
        load_reg(3'd0, 8'h01);
        exec(3'd1, 4'h1, 1'b0);
        check("sub_borrow", data_out, 8'hFF);
        check("sub_borrow_cout", {7'd0, cout}, 8'h01);
        load_reg(3'd0, 8'h05);
        exec(3'd1, 4'h1, 1'b1);
        check("sub_cin", data_out, 8'h02);
        check("sub_cin_cout", {7'd0, cout}, 8'h00);

        load_reg(3'd0, 8'h0F);
        exec(3'd3, 4'h4, 1'b0);
        check("xor", data_out, 8'h07);
        load_reg(3'd0, 8'h0F);
        exec(3'd3, 4'h6, 1'b0);
        check("and", data_out, 8'h08);
        load_reg(3'd0, 8'h0F);
        exec(3'd3, 4'h7, 1'b0);
        check("nand", data_out, 8'hF7);
        load_reg(3'd0, 8'h0F);
        exec(3'd3, 4'h8, 1'b0);
        check("or", data_out, 8'h0F);
        load_reg(3'd0, 8'h0F);
        exec(3'd3, 4'h9, 1'b0);
        check("nor", data_out, 8'hF0);
        check("nor_cout", {7'd0, cout}, 8'h00);

        load_reg(3'd0, 8'h08);
        exec(3'd3, 4'h5, 1'b0);
        check("cmp_equal", data_out, 8'h08);
        check("cmp_equal_cout", {7'd0, cout}, 8'h00);
`ifdef ZERO_FLAG_EN
        check("cmp_equal_zero", {7'd0, zero}, 8'h01);
`endif
        load_reg(3'd0, 8'h03);
        exec(3'd3, 4'h5, 1'b0);
        check("cmp_less", data_out, 8'h03);
        check("cmp_less_cout", {7'd0, cout}, 8'h01);

        load_reg(3'd0, 8'h11);
        check("load_keeps_cout", {7'd0, cout}, 8'h01);
        step(1'b0, 1'b0, 7'h10, 8'h00, 1'b1);
        check("ce0_data", data_out, 8'h11);
        check("ce0_cout", {7'd0, cout}, 8'h01);
        exec(3'd1, 4'hC, 1'b1);
        check("nop_data", data_out, 8'h11);
        check("nop_cout", {7'd0, cout}, 8'h01);

        load_reg(3'd0, 8'h01);
        for (int n = 1; n <= 3; n++) begin
            exec(3'd0, 4'h0, 1'b0);
            check($sformatf("chain%0d", n), data_out, 8'(1 << n));
        end

        exec(3'd4, 4'hA, 1'b0);
        check("regs_untouched", data_out, 8'h10);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_data", data_out, 8'h00);
        check("async_reset_cout", {7'd0, cout}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        exec(3'd7, 4'hA, 1'b0);
        check("reset_clears_regs", data_out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
